// File: rtl/mem_pkg.sv
// mem_pkg: command encoding and I/O map shared by the memory responder
// and the CPU controller.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_NONE    = 2'b00,
        MEM_WRITE   = 2'b01,
        MEM_READ    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_cmd_t;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } rsp_state_t;

    // Which source drives read_data since the last successful read.
    typedef enum logic [1:0] {
        RSEL_ZERO,
        RSEL_RAM,
        RSEL_SW
    } rd_sel_t;

endpackage

// File: rtl/ram_sp.sv
// ram_sp: single-port synchronous RAM with registered, enabled read.
// No reset so the array maps onto block RAM.
module ram_sp #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: decodes the CPU mem_cmd bus onto data RAM, LED register
// and synchronized switches; read data returns one cycle after the request.
module mem_responder #(
    parameter int                ADDR_W    = 9,
    parameter int                DATA_W    = 16,
    parameter int                RAM_WORDS = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR  = mem_pkg::LED_ADDR,
    parameter logic [ADDR_W-1:0] SW_ADDR   = mem_pkg::SW_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_valid,
    input  logic [7:0]        sw,
    output logic [7:0]        leds,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);
    import mem_pkg::*;

    localparam int              RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W+1)'(RAM_WORDS);

    mem_cmd_t          w_cmd;
    logic              w_in_ram;
    logic              w_is_read;
    logic              w_ram_we;
    logic              w_ram_re;
    logic              w_led_we;
    logic              w_sw_re;
    logic              w_bus_err;
    logic [DATA_W-1:0] w_ram_q;

    rsp_state_t        r_state;
    logic              r_rd_valid;
    rd_sel_t           r_rsel;
    logic [7:0]        r_sw_rd;
    logic [7:0]        r_leds;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;
    logic [7:0]        r_sync1;
    logic [7:0]        r_sync2;

    assign w_cmd     = mem_cmd_t'(mem_cmd);
    assign w_in_ram  = {1'b0, mem_addr} < RAM_LIMIT;
    assign w_is_read = (w_cmd == MEM_READ);

    always_comb begin
        w_ram_we  = 1'b0;
        w_ram_re  = 1'b0;
        w_led_we  = 1'b0;
        w_sw_re   = 1'b0;
        w_bus_err = 1'b0;
        unique case (w_cmd)
            MEM_NONE: begin
            end
            MEM_WRITE: begin
                if (w_in_ram)
                    w_ram_we = 1'b1;
                else if (mem_addr == LED_ADDR)
                    w_led_we = 1'b1;
                else
                    w_bus_err = 1'b1;
            end
            MEM_READ: begin
                if (w_in_ram)
                    w_ram_re = 1'b1;
                else if (mem_addr == SW_ADDR)
                    w_sw_re = 1'b1;
                else
                    w_bus_err = 1'b1;
            end
            MEM_ILLEGAL: begin
                w_bus_err = 1'b1;
            end
        endcase
    end

    ram_sp #(
        .DEPTH (RAM_WORDS),
        .WIDTH (DATA_W),
        .AW    (RAM_AW)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (mem_addr[RAM_AW-1:0]),
        .i_wdata (write_data),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsel     <= RSEL_ZERO;
            r_sw_rd    <= '0;
            r_leds     <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            if (w_led_we)
                r_leds <= write_data[7:0];
            if (w_ram_re)
                r_rsel <= RSEL_RAM;
            if (w_sw_re) begin
                r_rsel  <= RSEL_SW;
                r_sw_rd <= r_sync2;
            end
            // Only the first error is recorded until reset.
            if (w_bus_err && !r_err) begin
                r_err      <= 1'b1;
                r_err_addr <= mem_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rd_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_is_read) begin
                        r_state    <= ST_RESP;
                        r_rd_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_is_read) begin
                        r_rd_valid <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_rd_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // The RAM output register holds between reads; r_rsel picks the source.
    always_comb begin
        read_data = '0;
        unique case (r_rsel)
            RSEL_RAM: read_data = w_ram_q;
            RSEL_SW:  read_data = {{(DATA_W-8){1'b0}}, r_sw_rd};
            default:  read_data = '0;
        endcase
    end

    assign rd_valid = r_rd_valid;
    assign leds     = r_leds;
    assign err      = r_err;
    assign err_addr = r_err_addr;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of RAM, LED, switch, error capture,
// back-to-back reads and asynchronous reset.
module tb_mem_responder;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_valid;
    logic [7:0]  sw;
    logic [7:0]  leds;
    logic        err;
    logic [8:0]  err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .sw         (sw),
        .leds       (leds),
        .err        (err),
        .err_addr   (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a command, let one rising edge sample it, settle past the edge.
    task automatic issue(input mem_cmd_t c, input logic [8:0] a,
                         input logic [15:0] d);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        mem_cmd    = MEM_NONE;
        mem_addr   = '0;
        write_data = '0;
        sw         = 8'h00;
        #1;
        chk("rst_read_data", 32'(read_data), 32'h0);
        chk("rst_rd_valid",  32'(rd_valid),  32'h0);
        chk("rst_leds",      32'(leds),      32'h0);
        chk("rst_err",       32'(err),       32'h0);
        chk("rst_err_addr",  32'(err_addr),  32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // RAM write then read-back
        issue(MEM_WRITE, 9'd5, 16'hBEEF);
        chk("wr_no_valid", 32'(rd_valid), 32'h0);
        issue(MEM_READ, 9'd5, 16'h0);
        chk("rd5_data",  32'(read_data), 32'hBEEF);
        chk("rd5_valid", 32'(rd_valid),  32'h1);
        issue(MEM_NONE, 9'd0, 16'h0);
        chk("rd5_pulse_end", 32'(rd_valid),  32'h0);
        chk("rd5_hold",      32'(read_data), 32'hBEEF);

        // LED register; RAM word 0 left intact
        issue(MEM_WRITE, 9'd0, 16'h1111);
        issue(MEM_WRITE, LED_ADDR, 16'h12A5);
        chk("led_a5", 32'(leds), 32'hA5);
        issue(MEM_READ, 9'd0, 16'h0);
        chk("ram0_intact", 32'(read_data), 32'h1111);
        chk("no_err_yet",  32'(err),       32'h0);

        // Switch path: two-flop lag
        sw = 8'h3C;
        issue(MEM_READ, SW_ADDR, 16'h0);
        chk("sw_lag", 32'(read_data), 32'h0000);
        issue(MEM_NONE, 9'd0, 16'h0);
        issue(MEM_READ, SW_ADDR, 16'h0);
        chk("sw_3c",       32'(read_data), 32'h003C);
        chk("sw_rd_valid", 32'(rd_valid),  32'h1);

        // Bus errors: first one sticks
        issue(MEM_READ, 9'h1FF, 16'h0);
        chk("err_set",      32'(err),       32'h1);
        chk("err_addr_1ff", 32'(err_addr),  32'h1FF);
        chk("err_rd_valid", 32'(rd_valid),  32'h1);
        chk("err_rd_keep",  32'(read_data), 32'h003C);
        issue(MEM_ILLEGAL, 9'h010, 16'hFFFF);
        chk("err_sticky",    32'(err),       32'h1);
        chk("err_addr_keep", 32'(err_addr),  32'h1FF);
        chk("ill_no_valid",  32'(rd_valid),  32'h0);
        chk("ill_rd_keep",   32'(read_data), 32'h003C);
        chk("ill_leds_keep", 32'(leds),      32'hA5);
        issue(MEM_WRITE, 9'h180, 16'h00FF);
        chk("bad_wr_leds", 32'(leds), 32'hA5);

        // Back-to-back reads
        issue(MEM_WRITE, 9'd1, 16'd1);
        issue(MEM_WRITE, 9'd2, 16'd2);
        issue(MEM_WRITE, 9'd3, 16'd3);
        issue(MEM_READ, 9'd1, 16'h0);
        chk("b2b1_valid", 32'(rd_valid),  32'h1);
        chk("b2b1_data",  32'(read_data), 32'd1);
        issue(MEM_READ, 9'd2, 16'h0);
        chk("b2b2_valid", 32'(rd_valid),  32'h1);
        chk("b2b2_data",  32'(read_data), 32'd2);
        issue(MEM_READ, 9'd3, 16'h0);
        chk("b2b3_valid", 32'(rd_valid),  32'h1);
        chk("b2b3_data",  32'(read_data), 32'd3);
        issue(MEM_NONE, 9'd0, 16'h0);
        chk("b2b_end_valid", 32'(rd_valid),  32'h0);
        chk("b2b_end_data",  32'(read_data), 32'd3);

        // Reset asserted in the middle of a READ cycle
        issue(MEM_READ, 9'd5, 16'h0);
        chk("pre_rst_valid", 32'(rd_valid), 32'h1);
        mem_cmd  = MEM_READ;
        mem_addr = 9'd2;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_read_data", 32'(read_data), 32'h0);
        chk("arst_rd_valid",  32'(rd_valid),  32'h0);
        chk("arst_leds",      32'(leds),      32'h0);
        chk("arst_err",       32'(err),       32'h0);
        chk("arst_err_addr",  32'(err_addr),  32'h0);
        @(posedge clk);
        #1;
        mem_cmd = MEM_NONE;
        reset   = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_no_valid", 32'(rd_valid),  32'h0);
        chk("post_rst_data",     32'(read_data), 32'h0);
        issue(MEM_READ, 9'd5, 16'h0);
        chk("ram_survives_rst", 32'(read_data), 32'hBEEF);
        chk("post_rst_valid",   32'(rd_valid),  32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's `mem_cmd` bus. It decodes each cycle's command and address and services it from one of three places:
- a synchronous single-port data RAM;
- a memory-mapped LED output register;
- a synchronized switch input.

It sits between the CPU datapath/controller and the board I/O, and returns read data on the cycle after a read request, which is exactly when the controller's WRITE state consumes it.

## Interface
Parameters:
- `ADDR_W`, 9: address width.
- `DATA_W`, 16: word width.
- `RAM_WORDS`, 256: RAM depth, mapped at addresses 0 to RAM_WORDS-1.
- `LED_ADDR`, 9'h100: write-only LED register.
- `SW_ADDR`, 9'h140: read-only switch port.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `mem_cmd`  in  2  00 NONE, 01 WRITE, 10 READ, 11 illegal.
- `mem_addr`  in  ADDR_W  request address.
- `write_data`  in  DATA_W  store data.
- `read_data`  out  DATA_W  registered read result.
- `rd_valid`  out  1  one-cycle pulse; `read_data` updated this cycle.
- `sw`  in  DATA_W[7:0]  asynchronous board switches.
- `leds`  out  8  LED register.
- `err`  out  1  sticky bus-error flag.
- `err_addr`  out  ADDR_W  address of the first error.

## Operation
- Command decode happens every cycle. Command and address are sampled at the rising edge.
- WRITE to an address below RAM_WORDS: `ram[addr] <= write_data`.
- WRITE to `LED_ADDR`: `leds <= write_data[7:0]`.
- READ from an address below RAM_WORDS: `read_data <= ram[addr]`.
- READ from `SW_ADDR`: `read_data <= {8'b0, sw_sync}`.
- READ or WRITE to any other address is a bus error. The access has no effect: RAM, `leds` and `read_data` are unchanged. `rd_valid` still pulses for a READ so the requester never stalls.
- `mem_cmd`=11 is a bus error with no side effects.
- On the first bus error after reset: set `err` and capture `err_addr`. Later errors do not overwrite them. Only reset clears them.
- Switch synchronizer: a two-flop chain, so `sw_sync` lags `sw` by 2 clocks.
- Response FSM has two states:
  - IDLE: on READ go to RESP; otherwise stay in IDLE.
  - RESP: assert `rd_valid`. On READ stay in RESP (back-to-back reads give a pulse every cycle); otherwise return to IDLE.
- RAM contents are not reset.
- No read-during-write case exists, because there is one command per cycle.

## Timing
- READ issued in cycle N gives `read_data` and `rd_valid` valid in cycle N+1. `read_data` holds until the next successful READ.
- WRITE issued in cycle N is visible to a READ issued in cycle N+1.
- `leds` updates in cycle N+1.
- `err` asserts in cycle N+1 after the offending cycle.
- Reset values, applied asynchronously:
  - `read_data`=0, `rd_valid`=0, `leds`=0, `err`=0, `err_addr`=0;
  - synchronizer flops = 0;
  - FSM state = IDLE.
- Reset asserted during a READ cycle suppresses that response. No `rd_valid` follows reset deassertion.

## Structure
- Shared package `mem_pkg`:
  - `mem_cmd_t` enum: `MEM_NONE`, `MEM_WRITE`, `MEM_READ`, `MEM_ILLEGAL`;
  - `LED_ADDR`, `SW_ADDR` constants.
  
  The CPU controller imports the same package.
- Sub-module `ram_sp`: synchronous single-port RAM, parameterized on depth and width, with registered read. It has no reset, so it infers block RAM.
- Top level holds: address decode, LED register, switch synchronizer, response FSM, error capture.

## Test plan
- WRITE 16'hBEEF to address 5, then READ 5 in the next cycle: `read_data`=16'hBEEF and `rd_valid`=1 exactly one cycle after the READ.
- WRITE 16'h12A5 to `LED_ADDR`: `leds`=8'hA5 the next cycle, and RAM is unchanged (READ 0x100 mirror check not applicable).
- Set `sw`=8'h3C, wait 2 cycles, READ `SW_ADDR`: `read_data`=16'h003C.
- READ 9'h1FF, then issue `mem_cmd`=11 at address 9'h010: `err`=1 with `err_addr`=9'h1FF (first error retained), `rd_valid` pulses once, `read_data` keeps its prior value.
- Three back-to-back READs of addresses 1, 2, 3 preloaded with 1, 2, 3: `rd_valid` is high for 3 consecutive cycles with data 1, 2, 3.
- Assert `reset` mid-READ: all outputs go to 0 immediately, and no `rd_valid` pulse follows deassertion.
